// File: rtl/beta_csr_hpm_counters.sv
// beta_csr_hpm_counters: mcycle/minstret/mhpmcounterN, mhpmeventN, mcountinhibit and their read-only user shadows.
// Latency: read data, hit and illegal are combinational. CSR writes and increments land on the next clk_i edge. ovf_o is registered.
// Backpressure: none. Every opcode is accepted in the cycle it is presented, and the counters never stall.
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   csr_addr_i/_wdata_i    CSR address and write/set/clear operand
//   csr_op_i               bit0 set, bit1 clear (both = write), bit2 read
//   csr_en_i               opcode valid this cycle
//   csr_rdata_o            read data (0 unless a read hits counter space)
//   csr_hit_o              address lies in counter space and csr_en_i is high
//   csr_illegal_o          illegal counter access
//   instr_retired_i        minstret increment strobe
//   event_i                hpm event strobes; mhpmevent value s selects event_i[s-1]
//   ovf_o                  one-cycle wrap pulse per counter index (bit1 is always 0)
module beta_csr_hpm_counters #(
    parameter int DataWidth = 32,
    parameter int NumHpm    = 4,
    parameter int HpmWidth  = 40,
    parameter int NumEvents = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [11:0]          csr_addr_i,
    input  logic [DataWidth-1:0] csr_wdata_i,
    input  logic [2:0]           csr_op_i,
    input  logic                 csr_en_i,
    output logic [DataWidth-1:0] csr_rdata_o,
    output logic                 csr_hit_o,
    output logic                 csr_illegal_o,
    input  logic                 instr_retired_i,
    input  logic [NumEvents-1:0] event_i,
    output logic [NumHpm+2:0]    ovf_o
);

    // Counter index k matches the CSR index: 0 mcycle, 1 time (never stored), 2 minstret, 3.. hpm.
    localparam int NumCnt  = NumHpm + 3;
    localparam int NumHpmA = (NumHpm > 0) ? NumHpm : 1;
    localparam int EvW     = $clog2(NumEvents + 1);

    localparam logic [63:0]    HpmMask = {64{1'b1}} >> (64 - HpmWidth);
    localparam logic [31:0]    InhMask = 32'h5 | (((32'h1 << NumHpm) - 32'h1) << 3);
    localparam logic [EvW-1:0] MaxSel  = EvW'(NumEvents);

    logic [63:0]       cnt_q [NumCnt];
    logic [63:0]       cnt_d [NumCnt];
    logic [NumCnt-1:0] ovf_q;
    logic [NumCnt-1:0] ovf_d;
    logic [NumCnt-1:0] inc_vec;
    logic [31:0]       inh_q;
    logic [31:0]       inh_d;
    logic [EvW-1:0]    sel_q [NumHpmA];
    logic [EvW-1:0]    sel_d [NumHpmA];

    // Bit 0 stands for "no event", so mhpmevent value s indexes bit s directly.
    logic [NumEvents:0] evt_ext;
    assign evt_ext = {event_i, 1'b0};

    function automatic logic [DataWidth-1:0] apply_op(input logic [1:0]           op,
                                                      input logic [DataWidth-1:0] cur,
                                                      input logic [DataWidth-1:0] wd);
        logic [DataWidth-1:0] res;
        case (op)
            2'b01:   res = cur | wd;
            2'b10:   res = cur & ~wd;
            2'b11:   res = wd;
            default: res = cur;
        endcase
        return res;
    endfunction

    function automatic logic [63:0] cnt_mask(input int k);
        return (k >= 3) ? HpmMask : {64{1'b1}};
    endfunction

    // ---------------- address decode ----------------
    logic [4:0] idx;
    logic       hi_half;
    logic       ctr_slot;
    logic       in_b;
    logic       in_c;
    logic       in_m;
    logic       wr_op;
    logic       cnt_wr;

    assign idx      = csr_addr_i[4:0];
    assign hi_half  = csr_addr_i[7];
    // Inside B00-B9F/C00-C9F, only x00-x1F and x80-x9F are counter slots.
    assign ctr_slot = (csr_addr_i[6:5] == 2'b00);
    assign in_b     = (csr_addr_i[11:8] == 4'hB) && (csr_addr_i[7:0] < 8'hA0);
    assign in_c     = (csr_addr_i[11:8] == 4'hC) && (csr_addr_i[7:0] < 8'hA0);
    assign in_m     = (csr_addr_i[11:5] == 7'b0011_001);
    assign wr_op    = csr_en_i && (csr_op_i[1:0] != 2'b00);
    assign cnt_wr   = wr_op && in_b && ctr_slot;

    // ---------------- read mux and illegal detection ----------------
    logic [DataWidth-1:0] rd_val;
    logic                 illegal;

    always_comb begin
        rd_val  = '0;
        illegal = 1'b0;
        if (in_b || in_c) begin
            // Time slot, gaps between slots and any write to the shadows are illegal.
            if (!ctr_slot || idx == 5'd1 || (in_c && wr_op)) begin
                illegal = 1'b1;
            end
            if (ctr_slot) begin
                for (int k = 0; k < NumCnt; k++) begin
                    if (k != 1 && idx == 5'(k)) begin
                        rd_val = hi_half ? cnt_q[k][63:32] : cnt_q[k][31:0];
                    end
                end
            end
        end else if (in_m) begin
            if (idx == 5'd1 || idx == 5'd2) begin
                illegal = 1'b1;
            end
            if (idx == 5'd0) begin
                rd_val = inh_q;
            end
            for (int i = 0; i < NumHpm; i++) begin
                if (idx == 5'(3 + i)) begin
                    rd_val = DataWidth'(sel_q[i]);
                end
            end
        end
    end

    assign csr_hit_o     = csr_en_i && (in_b || in_c || in_m);
    assign csr_illegal_o = csr_hit_o && illegal;
    assign csr_rdata_o   = (csr_hit_o && csr_op_i[2]) ? rd_val : '0;

    // ---------------- increment sources ----------------
    always_comb begin
        inc_vec    = '0;
        inc_vec[0] = 1'b1;
        inc_vec[2] = instr_retired_i;
        for (int i = 0; i < NumHpm; i++) begin
            inc_vec[3 + i] = (sel_q[i] != '0) && (sel_q[i] <= MaxSel) && evt_ext[sel_q[i]];
        end
        inc_vec = inc_vec & ~inh_q[NumCnt-1:0];
    end

    // ---------------- counter next state ----------------
    // A CSR write to either half takes priority over, and swallows, that cycle's increment.
    always_comb begin
        for (int k = 0; k < NumCnt; k++) begin
            cnt_d[k] = cnt_q[k];
            ovf_d[k] = 1'b0;
            if (k != 1) begin
                if (cnt_wr && idx == 5'(k)) begin
                    if (hi_half) begin
                        cnt_d[k] = {apply_op(csr_op_i[1:0], cnt_q[k][63:32], csr_wdata_i),
                                    cnt_q[k][31:0]} & cnt_mask(k);
                    end else begin
                        cnt_d[k] = {cnt_q[k][63:32],
                                    apply_op(csr_op_i[1:0], cnt_q[k][31:0], csr_wdata_i)} & cnt_mask(k);
                    end
                end else if (inc_vec[k]) begin
                    cnt_d[k] = (cnt_q[k] + 64'd1) & cnt_mask(k);
                    ovf_d[k] = (cnt_q[k] == cnt_mask(k));
                end
            end
        end
    end

    // ---------------- inhibit and event selectors ----------------
    always_comb begin
        inh_d = inh_q;
        for (int i = 0; i < NumHpmA; i++) begin
            sel_d[i] = sel_q[i];
        end
        if (wr_op && in_m) begin
            if (idx == 5'd0) begin
                inh_d = apply_op(csr_op_i[1:0], inh_q, csr_wdata_i) & InhMask;
            end
            for (int i = 0; i < NumHpm; i++) begin
                if (idx == 5'(3 + i)) begin
                    sel_d[i] = EvW'(apply_op(csr_op_i[1:0], DataWidth'(sel_q[i]), csr_wdata_i));
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < NumCnt; k++) begin
                cnt_q[k] <= '0;
            end
            for (int i = 0; i < NumHpmA; i++) begin
                sel_q[i] <= '0;
            end
            ovf_q <= '0;
            inh_q <= '0;
        end else begin
            for (int k = 0; k < NumCnt; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            for (int i = 0; i < NumHpmA; i++) begin
                sel_q[i] <= sel_d[i];
            end
            ovf_q <= ovf_d;
            inh_q <= inh_d;
        end
    end

    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_beta_csr_hpm_counters.sv
// tb_beta_csr_hpm_counters: directed CSR vectors with a queue of expected responses per opcode.
// Latency: each opcode is checked at the falling edge of the cycle in which it is presented.
// Backpressure: none; the monitor pops one expectation per enabled opcode.
module tb_beta_csr_hpm_counters;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [2:0]  csr_op_i;
    logic        csr_en_i;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;
    logic        csr_illegal_o;
    logic        instr_retired_i;
    logic [7:0]  event_i;
    logic [6:0]  ovf_o;

    always #5 clk_i = ~clk_i;

    beta_csr_hpm_counters #(
        .DataWidth (32),
        .NumHpm    (4),
        .HpmWidth  (40),
        .NumEvents (8)
    ) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .csr_addr_i      (csr_addr_i),
        .csr_wdata_i     (csr_wdata_i),
        .csr_op_i        (csr_op_i),
        .csr_en_i        (csr_en_i),
        .csr_rdata_o     (csr_rdata_o),
        .csr_hit_o       (csr_hit_o),
        .csr_illegal_o   (csr_illegal_o),
        .instr_retired_i (instr_retired_i),
        .event_i         (event_i),
        .ovf_o           (ovf_o)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        hit;
        logic        ill;
        logic [6:0]  ovf;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    checks = 0;
    int    errors = 0;

    // Drive an opcode in the current cycle and queue its expected response.
    task automatic drv(input logic [11:0] a, input logic [2:0] o, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eh, input logic ei,
                       input logic [6:0] eo, input string nm);
        exp_t e;
        csr_en_i    = 1'b1;
        csr_addr_i  = a;
        csr_op_i    = o;
        csr_wdata_i = wd;
        event_i     = '0;
        e.rd  = erd;
        e.hit = eh;
        e.ill = ei;
        e.ovf = eo;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic op(input logic [11:0] a, input logic [2:0] o, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eh, input logic ei,
                      input logic [6:0] eo, input string nm);
        @(posedge clk_i);
        #1;
        drv(a, o, wd, erd, eh, ei, eo, nm);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] erd, input string nm);
        op(a, 3'b100, 32'h0, erd, 1'b1, 1'b0, 7'h00, nm);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] wd, input string nm);
        op(a, 3'b011, wd, 32'h0, 1'b1, 1'b0, 7'h00, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
            csr_en_i = 1'b0;
            event_i  = '0;
        end
    endtask

    task automatic pulse(input logic [7:0] ev);
        @(posedge clk_i);
        #1;
        csr_en_i = 1'b0;
        event_i  = ev;
    endtask

    // Monitor: every enabled opcode produces a response to compare.
    exp_t  mon_e;
    string mon_nm;
    always @(negedge clk_i) begin
        if (csr_en_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response: addr %h got response, expected none queued", csr_addr_i);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_nm = name_q.pop_front();
                checks++;
                if (csr_rdata_o !== mon_e.rd) begin
                    errors++;
                    $display("FAIL %s rdata: got %h expected %h", mon_nm, csr_rdata_o, mon_e.rd);
                end
                checks++;
                if (csr_hit_o !== mon_e.hit) begin
                    errors++;
                    $display("FAIL %s hit: got %b expected %b", mon_nm, csr_hit_o, mon_e.hit);
                end
                checks++;
                if (csr_illegal_o !== mon_e.ill) begin
                    errors++;
                    $display("FAIL %s illegal: got %b expected %b", mon_nm, csr_illegal_o, mon_e.ill);
                end
                checks++;
                if (ovf_o !== mon_e.ovf) begin
                    errors++;
                    $display("FAIL %s ovf: got %b expected %b", mon_nm, ovf_o, mon_e.ovf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected the sequence to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn_i          = 1'b0;
        csr_en_i        = 1'b0;
        csr_addr_i      = '0;
        csr_op_i        = '0;
        csr_wdata_i     = '0;
        instr_retired_i = 1'b0;
        event_i         = '0;

        // Reset state
        repeat (2) @(posedge clk_i);
        rd(12'hB00, 32'h0, "rst_mcycle");
        rd(12'h320, 32'h0, "rst_inhibit");
        rd(12'hB02, 32'h0, "rst_minstret");
        @(posedge clk_i);
        #2;
        csr_en_i = 1'b0;
        rstn_i   = 1'b1;

        // Free-running mcycle after ten edges
        idle(9);
        rd(12'hB00, 32'd10, "mcycle_10");
        rd(12'hB80, 32'h0, "mcycle_hi_0");
        rd(12'hB02, 32'h0, "minstret_0");

        // Half writes, dropped increment, carry into high half
        wr(12'hB00, 32'hFFFF_FFFE, "wr_mcycle_lo");
        wr(12'hB80, 32'h0, "wr_mcycle_hi");
        rd(12'hB00, 32'hFFFF_FFFE, "mcycle_no_inc_on_write");
        rd(12'hB00, 32'hFFFF_FFFF, "mcycle_lo_ff");
        rd(12'hB00, 32'h0, "mcycle_lo_wrap");
        rd(12'hB80, 32'h1, "mcycle_hi_carry");

        // Read-modify-write returns the old value; set and clear
        op(12'hB02, 3'b111, 32'h5, 32'h0, 1'b1, 1'b0, 7'h00, "rmw_write_old");
        rd(12'hB02, 32'h5, "minstret_5");
        op(12'hB02, 3'b101, 32'h30, 32'h5, 1'b1, 1'b0, 7'h00, "rmw_set_old");
        op(12'hB02, 3'b110, 32'h05, 32'h35, 1'b1, 1'b0, 7'h00, "rmw_clear_old");
        rd(12'hB02, 32'h30, "minstret_30");
        rd(12'hB82, 32'h0, "minstret_hi");
        rd(12'hC02, 32'h30, "instret_shadow");

        // Event selection and per-counter inhibit
        wr(12'h323, 32'hFFFF_FFF2, "wr_event3");
        rd(12'h323, 32'h2, "event3_field_width");
        repeat (5) pulse(8'h02);
        repeat (3) pulse(8'h01);
        rd(12'hB03, 32'h5, "hpm3_count_5");
        op(12'h320, 3'b001, 32'h8, 32'h0, 1'b1, 1'b0, 7'h00, "set_inhibit3");
        repeat (4) pulse(8'h02);
        rd(12'hB03, 32'h5, "hpm3_inhibited");
        rd(12'h320, 32'h8, "inhibit_bit3");
        rd(12'hB83, 32'h0, "hpm3_hi_0");
        wr(12'h320, 32'hFFFF_FFFF, "wr_inhibit_all");
        rd(12'h320, 32'h0000_007D, "inhibit_mask");
        wr(12'hB00, 32'h1234, "wr_mcycle_inhibited");
        rd(12'hB00, 32'h1234, "mcycle_held_a");
        rd(12'hB00, 32'h1234, "mcycle_held_b");
        wr(12'h320, 32'h0, "clr_inhibit");
        rd(12'hB00, 32'h1234, "inhibit_next_cycle");
        rd(12'hB00, 32'h1235, "mcycle_resumes");
        wr(12'h33F, 32'hFFFF_FFFF, "wr_event31_unimpl");
        rd(12'h33F, 32'h0, "event31_unimpl");
        wr(12'h327, 32'h3, "wr_event7_unimpl");
        rd(12'h327, 32'h0, "event7_unimpl");

        // 40-bit wrap and overflow pulse
        wr(12'hB83, 32'hFF, "wr_hpm3_hi");
        wr(12'hB03, 32'hFFFF_FFFF, "wr_hpm3_lo");
        rd(12'hB83, 32'hFF, "hpm3_hi_ff");
        rd(12'hB03, 32'hFFFF_FFFF, "hpm3_lo_ff");
        pulse(8'h02);
        op(12'hB03, 3'b100, 32'h0, 32'h0, 1'b1, 1'b0, 7'b000_1000, "hpm3_wrap_ovf");
        rd(12'hB83, 32'h0, "ovf_one_cycle");
        wr(12'hB83, 32'hFFFF_FFFF, "wr_hpm3_hi_wide");
        rd(12'hB83, 32'hFF, "hpm3_hi_masked");
        rd(12'hC83, 32'hFF, "hpm3_shadow_hi");
        rd(12'hC03, 32'h0, "hpm3_shadow_lo");

        // Illegal and out-of-range accesses
        wr(12'hB00, 32'h100, "wr_mcycle_100");
        op(12'hC00, 3'b111, 32'h0, 32'h100, 1'b1, 1'b1, 7'h00, "c_write_illegal");
        rd(12'hB00, 32'h101, "mcycle_unaffected");
        op(12'hB01, 3'b100, 32'h0, 32'h0, 1'b1, 1'b1, 7'h00, "time_b01");
        op(12'hC81, 3'b100, 32'h0, 32'h0, 1'b1, 1'b1, 7'h00, "time_c81");
        rd(12'hB07, 32'h0, "unimpl_b07");
        wr(12'hB07, 32'h55, "wr_unimpl_b07");
        rd(12'hB07, 32'h0, "unimpl_b07_after");
        op(12'h300, 3'b100, 32'h0, 32'h0, 1'b0, 1'b0, 7'h00, "miss_300");
        op(12'h321, 3'b100, 32'h0, 32'h0, 1'b1, 1'b1, 7'h00, "illegal_321");
        op(12'h322, 3'b011, 32'h1, 32'h0, 1'b1, 1'b1, 7'h00, "illegal_322");
        op(12'hB20, 3'b100, 32'h0, 32'h0, 1'b1, 1'b1, 7'h00, "gap_b20");
        op(12'hBA0, 3'b100, 32'h0, 32'h0, 1'b0, 1'b0, 7'h00, "miss_ba0");

        // Asynchronous reset mid-operation
        @(posedge clk_i);
        #1;
        csr_en_i        = 1'b0;
        instr_retired_i = 1'b1;
        rd(12'hB02, 32'h31, "minstret_counting");
        @(posedge clk_i);
        #1;
        rstn_i = 1'b0;
        #1;
        drv(12'hB02, 3'b100, 32'h0, 32'h0, 1'b1, 1'b0, 7'h00, "async_rst_minstret");
        rd(12'hB00, 32'h0, "async_rst_mcycle");
        rd(12'hB03, 32'h0, "async_rst_hpm3");
        rd(12'h323, 32'h0, "async_rst_event3");
        rd(12'h320, 32'h0, "async_rst_inhibit");
        @(posedge clk_i);
        #2;
        csr_en_i = 1'b0;
        rstn_i   = 1'b1;
        rd(12'hB02, 32'h1, "post_rst_minstret_1");
        rd(12'hB02, 32'h2, "post_rst_minstret_2");
        rd(12'hB00, 32'h3, "post_rst_mcycle_3");

        @(posedge clk_i);
        #1;
        csr_en_i        = 1'b0;
        instr_retired_i = 1'b0;
        @(posedge clk_i);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
